// File: rtl/game_map.sv
// game_map: wall bitmap for the game field.
//   Loads a fixed maze pattern one row per cycle when the game starts, serves
//   two independent registered read ports (display and collision query), and
//   clears destructible walls through a small 2-entry request FIFO that only
//   drains while the display is not busy.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_state                 game state (01 = game running)
//   i_buzy                  display busy; map clears held off while high
//   i_request_x/y, o_is_wall      display-side read (1-cycle latency)
//   i_query_x/y, o_query_wall     collision read (1-cycle latency)
//   i_destroy_valid/x/y, o_destroy_ready   destroy request handshake
//   o_map_ready             map fully loaded
//   o_destroyed_cnt         walls cleared since last load (saturating)
module game_map #(
  parameter int unsigned MAP_W = 64,
  parameter int unsigned MAP_H = 44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_state,
  input  logic       i_buzy,
  input  logic [5:0] i_request_x,
  input  logic [5:0] i_request_y,
  output logic       o_is_wall,
  input  logic [5:0] i_query_x,
  input  logic [5:0] i_query_y,
  output logic       o_query_wall,
  input  logic       i_destroy_valid,
  input  logic [5:0] i_destroy_x,
  input  logic [5:0] i_destroy_y,
  output logic       o_destroy_ready,
  output logic       o_map_ready,
  output logic [7:0] o_destroyed_cnt
);

  localparam int unsigned CW     = 6;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ENT_W  = 2 * CW;
  localparam int unsigned OCC_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      row_q, row_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   fifo_q [2];
  logic [ENT_W-1:0]   fifo_d [2];
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               ready_q, ready_d;
  logic               map_ready_q;
  logic               is_wall_q, is_wall_d;
  logic               query_wall_q, query_wall_d;
  logic [MAP_W-1:0]   map_q [MAP_H];

  logic               game_on;
  logic               push, pop, hit;
  logic [CW-1:0]      head_x, head_y;

  // Maze pattern for one row: solid border plus 2x2 pillars on an 8-cell pitch.
  function automatic logic [MAP_W-1:0] row_pattern(input logic [CW-1:0] y);
    logic [MAP_W-1:0] r;
    logic             y_pil;
    y_pil = (y[2:0] == 3'd3) || (y[2:0] == 3'd4);
    for (int unsigned x = 0; x < MAP_W; x++) begin
      r[x] = (x == 0) || (x == MAP_W - 1) || (y == '0) || (32'(y) == MAP_H - 1) ||
             ((((x % 8) == 3) || ((x % 8) == 4)) && y_pil);
    end
    return r;
  endfunction

  assign game_on = (i_state == 2'b01);
  assign head_x  = fifo_q[0][ENT_W-1:CW];
  assign head_y  = fifo_q[0][CW-1:0];

  // Handshake and drain; a pop only happens when READY persists past this edge.
  assign push = i_destroy_valid && ready_q;
  assign pop  = (state_q == ST_READY) && game_on && !i_buzy && (occ_q != '0);

  // Popped cell is cleared only if it is an interior cell that is still a wall.
  assign hit = pop &&
               (32'(head_x) < MAP_W) && (32'(head_y) < MAP_H) &&
               (head_x != '0) && (32'(head_x) != MAP_W - 1) &&
               (head_y != '0) && (32'(head_y) != MAP_H - 1) &&
               map_q[head_y][head_x];

  // Next-state: FSM, row counter, destroy counter, FIFO.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    fifo_d  = fifo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (game_on) begin
          state_d = ST_LOAD;
          row_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (!game_on) begin
          state_d = ST_IDLE;
        end else if (32'(row_q) == MAP_H - 1) begin
          state_d = ST_READY;
        end else begin
          row_d = row_q + CW'(1);
        end
      end
      ST_READY: begin
        if (!game_on) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Pop shifts the tail forward before a push lands behind it, keeping order.
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      occ_d     = occ_q - OCC_W'(1);
    end
    if (push) begin
      fifo_d[occ_d[0]] = {i_destroy_x, i_destroy_y};
      occ_d            = occ_d + OCC_W'(1);
    end
    if (state_d != ST_READY) begin
      occ_d = '0;
    end
  end

  // Registered outputs precomputed from next state so they match the current state.
  always_comb begin
    ready_d = (state_d == ST_READY) && (occ_d != OCC_W'(2));

    is_wall_d = 1'b0;
    if ((32'(i_request_y) < MAP_H) && (32'(i_request_x) < MAP_W)) begin
      is_wall_d = map_q[i_request_y][i_request_x];
    end

    query_wall_d = 1'b0;
    if ((32'(i_query_y) < MAP_H) && (32'(i_query_x) < MAP_W)) begin
      query_wall_d = map_q[i_query_y][i_query_x];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      occ_q        <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      ready_q      <= 1'b0;
      map_ready_q  <= 1'b0;
      is_wall_q    <= 1'b0;
      query_wall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      fifo_q       <= fifo_d;
      ready_q      <= ready_d;
      map_ready_q  <= (state_d == ST_READY);
      is_wall_q    <= is_wall_d;
      query_wall_q <= query_wall_d;
    end
  end

  // Map storage: row fill during LOAD, single-cell clear on a destroy hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAP_H); i++) begin
        map_q[i] <= '0;
      end
    end else if (state_q == ST_LOAD) begin
      map_q[row_q] <= row_pattern(row_q);
    end else if (hit) begin
      map_q[head_y][head_x] <= 1'b0;
    end
  end

  assign o_is_wall       = is_wall_q;
  assign o_query_wall    = query_wall_q;
  assign o_destroy_ready = ready_q;
  assign o_map_ready     = map_ready_q;
  assign o_destroyed_cnt = cnt_q;

endmodule

// File: tb/tb_game_map.sv
// Testbench for game_map: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the wall map.
module tb_game_map;

  localparam int W = 64;
  localparam int H = 44;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] st;
  logic       buzy;
  logic [5:0] rx, ry, qx, qy, dx, dy;
  logic       dv;
  logic       o_is_wall, o_query_wall, o_destroy_ready, o_map_ready;
  logic [7:0] o_destroyed_cnt;

  always #5 clk = ~clk;

  game_map dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_state         (st),
    .i_buzy          (buzy),
    .i_request_x     (rx),
    .i_request_y     (ry),
    .o_is_wall       (o_is_wall),
    .i_query_x       (qx),
    .i_query_y       (qy),
    .o_query_wall    (o_query_wall),
    .i_destroy_valid (dv),
    .i_destroy_x     (dx),
    .i_destroy_y     (dy),
    .o_destroy_ready (o_destroy_ready),
    .o_map_ready     (o_map_ready),
    .o_destroyed_cnt (o_destroyed_cnt)
  );

  // Reference model state.
  bit          mmap [H][W];
  int          mst, mrow, mcnt;
  logic [11:0] fq [$];
  bit          exp_is, exp_q;
  int          errors = 0;
  int          checks = 0;

  function automatic bit pattern(int x, int y);
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 1'b1;
    return ((x % 8 == 3) || (x % 8 == 4)) && ((y % 8 == 3) || (y % 8 == 4));
  endfunction

  function automatic bit cleanable(int x, int y);
    if (x <= 0 || x >= W - 1 || y <= 0 || y >= H - 1) return 1'b0;
    return mmap[y][x];
  endfunction

  task automatic model_reset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mmap[y][x] = 1'b0;
    mst = M_IDLE; mrow = 0; mcnt = 0; fq.delete();
    exp_is = 1'b0; exp_q = 1'b0;
  endtask

  function automatic bit exp_ready();
    return (mst == M_READY) && (fq.size() < 2);
  endfunction

  // Advance DUT and model by one clock edge using the currently driven inputs.
  task automatic cycle();
    bit push, pop;
    logic [11:0] e;
    int px, py;
    exp_is = (int'(ry) < H) ? mmap[ry][rx] : 1'b0;
    exp_q  = (int'(qy) < H) ? mmap[qy][qx] : 1'b0;
    push = dv && exp_ready();
    pop  = (mst == M_READY) && (st == 2'b01) && !buzy && (fq.size() > 0);
    if (pop) begin
      e = fq.pop_front();
      px = int'(e[11:6]); py = int'(e[5:0]);
      if (cleanable(px, py)) begin
        mmap[py][px] = 1'b0;
        if (mcnt < 255) mcnt++;
      end
    end
    if (push) fq.push_back({dx, dy});
    case (mst)
      M_IDLE: if (st == 2'b01) begin mst = M_LOAD; mrow = 0; mcnt = 0; end
      M_LOAD: begin
        for (int x = 0; x < W; x++) mmap[mrow][x] = pattern(x, mrow);
        if (st != 2'b01) mst = M_IDLE;
        else if (mrow == H - 1) mst = M_READY;
        else mrow++;
      end
      default: if (st != 2'b01) begin mst = M_IDLE; fq.delete(); end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st = 2'b00; buzy = 1'b0; dv = 1'b0;
    rx = '0; ry = '0; qx = '0; qy = '0; dx = '0; dy = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_is_wall !== 1'b0)       begin errors++; $display("FAIL reset_is_wall got=%b exp=0", o_is_wall); end
    checks++; if (o_query_wall !== 1'b0)    begin errors++; $display("FAIL reset_query got=%b exp=0", o_query_wall); end
    checks++; if (o_destroy_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_destroy_ready); end
    checks++; if (o_map_ready !== 1'b0)     begin errors++; $display("FAIL reset_map_ready got=%b exp=0", o_map_ready); end
    checks++; if (o_destroyed_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_destroyed_cnt); end
    rst_n = 1'b1;
    cycle();
  endtask

  // Assert game state and count edges until the map is ready.
  task automatic load_and_count(input string name);
    int n;
    st = 2'b01; n = 0;
    while (o_map_ready !== 1'b1 && n < 100) begin cycle(); n++; end
    checks++; if (n !== 45) begin errors++; $display("FAIL %s_latency got=%0d exp=45", name, n); end
    checks++; if (o_destroy_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b exp=1", name, o_destroy_ready); end
  endtask

  task automatic test_load();
    int cx [5] = '{0, 3, 5, 63, 10};
    int cy [5] = '{0, 3, 5, 43, 20};
    bit ce [5] = '{1, 1, 0, 1, 0};
    load_and_count("load");
    for (int i = 0; i < 5; i++) begin
      rx = 6'(cx[i]); ry = 6'(cy[i]); qx = 6'(cx[i]); qy = 6'(cy[i]);
      cycle();
      checks++; if (o_is_wall !== ce[i]) begin errors++; $display("FAIL load_cell(%0d,%0d) got=%b exp=%b", cx[i], cy[i], o_is_wall, ce[i]); end
      checks++; if (o_query_wall !== ce[i]) begin errors++; $display("FAIL load_query(%0d,%0d) got=%b exp=%b", cx[i], cy[i], o_query_wall, ce[i]); end
    end
  endtask

  task automatic test_read_latency();
    rx = 6'd3; ry = 6'd11; qx = 6'd0; qy = 6'd50;
    cycle();
    checks++; if (o_is_wall !== 1'b1) begin errors++; $display("FAIL read_3_11 got=%b exp=1", o_is_wall); end
    checks++; if (o_query_wall !== 1'b0) begin errors++; $display("FAIL query_y50 got=%b exp=0", o_query_wall); end
    rx = 6'd0; ry = 6'd50;
    cycle();
    checks++; if (o_is_wall !== 1'b0) begin errors++; $display("FAIL read_y50 got=%b exp=0", o_is_wall); end
    for (int i = 0; i < 40; i++) begin
      rx = 6'($urandom); ry = 6'($urandom); qx = 6'($urandom); qy = 6'($urandom);
      cycle();
      checks++; if (o_is_wall !== exp_is) begin errors++; $display("FAIL rand_read(%0d,%0d) got=%b exp=%b", rx, ry, o_is_wall, exp_is); end
      checks++; if (o_query_wall !== exp_q) begin errors++; $display("FAIL rand_query(%0d,%0d) got=%b exp=%b", qx, qy, o_query_wall, exp_q); end
    end
  endtask

  task automatic test_destroy_busy();
    buzy = 1'b1; dv = 1'b1;
    dx = 6'd3; dy = 6'd3; cycle();
    checks++; if (o_destroy_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_1 got=%b exp=1", o_destroy_ready); end
    dx = 6'd4; dy = 6'd4; cycle();
    checks++; if (o_destroy_ready !== 1'b0) begin errors++; $display("FAIL busy_full got=%b exp=0", o_destroy_ready); end
    dx = 6'd5; dy = 6'd5; cycle();
    checks++; if (o_destroy_ready !== 1'b0) begin errors++; $display("FAIL busy_third got=%b exp=0", o_destroy_ready); end
    dv = 1'b0; buzy = 1'b0; rx = 6'd3; ry = 6'd3;
    cycle();
    checks++; if (o_is_wall !== 1'b1) begin errors++; $display("FAIL preclear_3_3 got=%b exp=1", o_is_wall); end
    checks++; if (o_destroyed_cnt !== 8'd1) begin errors++; $display("FAIL cnt_after_1 got=%0d exp=1", o_destroyed_cnt); end
    qx = 6'd4; qy = 6'd4;
    cycle();
    checks++; if (o_is_wall !== 1'b0) begin errors++; $display("FAIL cleared_3_3 got=%b exp=0", o_is_wall); end
    checks++; if (o_query_wall !== 1'b1) begin errors++; $display("FAIL preclear_4_4 got=%b exp=1", o_query_wall); end
    cycle();
    checks++; if (o_query_wall !== 1'b0) begin errors++; $display("FAIL cleared_4_4 got=%b exp=0", o_query_wall); end
    checks++; if (o_destroyed_cnt !== 8'd2) begin errors++; $display("FAIL cnt_after_2 got=%0d exp=2", o_destroyed_cnt); end
    checks++; if (o_destroy_ready !== 1'b1) begin errors++; $display("FAIL drained_ready got=%b exp=1", o_destroy_ready); end
  endtask

  task automatic test_discard();
    buzy = 1'b0; dv = 1'b1;
    dx = 6'd0; dy = 6'd5; cycle();
    dx = 6'd5; dy = 6'd5; cycle();
    dv = 1'b0; cycle();
    rx = 6'd0; ry = 6'd5; qx = 6'd5; qy = 6'd5;
    cycle();
    checks++; if (o_is_wall !== 1'b1) begin errors++; $display("FAIL border_kept got=%b exp=1", o_is_wall); end
    checks++; if (o_query_wall !== 1'b0) begin errors++; $display("FAIL empty_kept got=%b exp=0", o_query_wall); end
    checks++; if (o_destroyed_cnt !== 8'd2) begin errors++; $display("FAIL discard_cnt got=%0d exp=2", o_destroyed_cnt); end
  endtask

  task automatic test_state_exit();
    buzy = 1'b1; dv = 1'b1; dx = 6'd11; dy = 6'd11;
    cycle();
    dv = 1'b0;
    checks++; if (o_destroy_ready !== 1'b1) begin errors++; $display("FAIL exit_one_entry got=%b exp=1", o_destroy_ready); end
    st = 2'b00;
    cycle();
    checks++; if (o_map_ready !== 1'b0) begin errors++; $display("FAIL exit_map_ready got=%b exp=0", o_map_ready); end
    checks++; if (o_destroy_ready !== 1'b0) begin errors++; $display("FAIL exit_ready got=%b exp=0", o_destroy_ready); end
    buzy = 1'b0; rx = 6'd11; ry = 6'd11; qx = 6'd3; qy = 6'd3;
    repeat (2) cycle();
    checks++; if (o_is_wall !== 1'b1) begin errors++; $display("FAIL exit_target_wall got=%b exp=1", o_is_wall); end
    checks++; if (o_query_wall !== 1'b0) begin errors++; $display("FAIL exit_map_retained got=%b exp=0", o_query_wall); end
    load_and_count("reload");
    repeat (3) cycle();
    checks++; if (o_destroyed_cnt !== 8'd0) begin errors++; $display("FAIL exit_flushed_cnt got=%0d exp=0", o_destroyed_cnt); end
    checks++; if (o_is_wall !== 1'b1) begin errors++; $display("FAIL exit_reload_wall got=%b exp=1", o_is_wall); end
  endtask

  task automatic test_mid_load_reset();
    st = 2'b00; cycle();
    st = 2'b01;
    repeat (21) cycle();
    checks++; if (o_map_ready !== 1'b0) begin errors++; $display("FAIL midload_not_ready got=%b exp=0", o_map_ready); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (o_is_wall !== 1'b0 || o_query_wall !== 1'b0) begin errors++; $display("FAIL midload_rst_reads got=%b%b exp=00", o_is_wall, o_query_wall); end
    checks++; if (o_destroyed_cnt !== 8'd0) begin errors++; $display("FAIL midload_rst_cnt got=%0d exp=0", o_destroyed_cnt); end
    st = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rx = 6'd0; ry = 6'd0; qx = 6'd3; qy = 6'd3;
    repeat (2) cycle();
    checks++; if (o_is_wall !== 1'b0) begin errors++; $display("FAIL midload_zero_0_0 got=%b exp=0", o_is_wall); end
    checks++; if (o_query_wall !== 1'b0) begin errors++; $display("FAIL midload_zero_3_3 got=%b exp=0", o_query_wall); end
    checks++; if (o_map_ready !== 1'b0) begin errors++; $display("FAIL midload_idle got=%b exp=0", o_map_ready); end
    for (int i = 0; i < 20; i++) begin
      rx = 6'($urandom_range(0, W - 1)); ry = 6'($urandom_range(0, H - 1));
      cycle();
      checks++; if (o_is_wall !== 1'b0) begin errors++; $display("FAIL midload_zero(%0d,%0d) got=%b exp=0", rx, ry, o_is_wall); end
    end
    load_and_count("midload_reload");
    rx = 6'd3; ry = 6'd3; cycle();
    checks++; if (o_is_wall !== 1'b1) begin errors++; $display("FAIL midload_reload_3_3 got=%b exp=1", o_is_wall); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      buzy = ($urandom_range(0, 3) == 0);
      dv   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        dx = {3'($urandom), 3'(3 + $urandom_range(0, 1))};
        dy = {3'($urandom_range(0, 5)), 3'(3 + $urandom_range(0, 1))};
      end else begin
        dx = 6'($urandom); dy = 6'($urandom);
      end
      rx = 6'($urandom); ry = 6'($urandom); qx = 6'($urandom); qy = 6'($urandom);
      cycle();
      checks++; if (o_is_wall !== exp_is) begin errors++; $display("FAIL rnd_read(%0d,%0d) got=%b exp=%b", rx, ry, o_is_wall, exp_is); end
      checks++; if (o_query_wall !== exp_q) begin errors++; $display("FAIL rnd_query(%0d,%0d) got=%b exp=%b", qx, qy, o_query_wall, exp_q); end
      checks++; if (o_destroy_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready got=%b exp=%b", o_destroy_ready, exp_ready()); end
      checks++; if (o_destroyed_cnt !== 8'(mcnt)) begin errors++; $display("FAIL rnd_cnt got=%0d exp=%0d", o_destroyed_cnt, mcnt); end
    end
    dv = 1'b0; buzy = 1'b0;
    repeat (3) cycle();
    // Full-map sweep: even rows on the display port, odd rows on the query port.
    for (int y = 0; y < H; y += 2) begin
      for (int x = 0; x < W; x++) begin
        rx = 6'(x); ry = 6'(y); qx = 6'(x); qy = 6'(y + 1);
        cycle();
        checks++; if (o_is_wall !== exp_is) begin errors++; $display("FAIL sweep(%0d,%0d) got=%b exp=%b", x, y, o_is_wall, exp_is); end
        checks++; if (o_query_wall !== exp_q) begin errors++; $display("FAIL sweep(%0d,%0d) got=%b exp=%b", x, y + 1, o_query_wall, exp_q); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read_latency();
    test_destroy_busy();
    test_discard();
    test_state_exit();
    test_mid_load_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
